dither_scheduler: RTL and testbench

Sequencing controller for the Floyd-Steinberg dithering engine. On `start` it walks every pixel of the image held in the dual-port pixel SRAM in raster order. For each pixel it reads the old value, writes back the thresholded value, and applies read-modify-write error diffusion to the E, SW, S and SE neighbours. It sits between the host/start logic and the `mem_block` SRAM. Port A is used read-only and port B write-only; the top level ties `wren_a` and `rden_b` low while this block owns the SRAM.

---
 rtl/dither_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_dither_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dither_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dither_scheduler: raster-order Floyd-Steinberg sequencer over a dual-port   |
// | pixel SRAM. Optional macro DITHER_SATURATE_EN clamps updates to 0..255.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dither_scheduler #(
  parameter int IMAGEX   = 64,
  parameter int IMAGEY   = 64,
  parameter int RGB_SIZE = 8,
  parameter int THRESH   = 128,
  localparam int PIX_W   = $clog2(IMAGEX * IMAGEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [PIX_W-1:0]    pixel_idx,
  output logic [15:0]         addr_a,
  output logic                rden_a,
  input  logic [RGB_SIZE-1:0] q_a,
  output logic [15:0]         addr_b,
  output logic                wren_b,
  output logic [RGB_SIZE-1:0] data_b
);

  localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam logic [XW-1:0] c_X_LAST = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] c_Y_LAST = YW'(IMAGEY - 1);
  localparam logic [8:0]    c_THRESH = 9'(THRESH);

  if (RGB_SIZE != 8) begin : g_rgb_check
    $error("dither_scheduler supports only RGB_SIZE == 8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RD_OLD, S_QUANT, S_E, S_SW, S_S, S_SE, S_DONE
  } state_t;

  state_t              r_state;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [PIX_W-1:0]    r_p;
  logic signed [8:0]   r_err;

  logic [RGB_SIZE-1:0] w_new;
  logic signed [8:0]   w_err;
  logic [3:0]          w_weight;
  logic signed [12:0]  w_prod;
  logic [RGB_SIZE-1:0] w_upd;
  logic [15:0]         w_p16;
  logic                w_x_last, w_x_first, w_y_last;
  logic                w_ok_e, w_ok_sw, w_ok_s, w_ok_se;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_p     <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RD_OLD;
            r_x     <= '0;
            r_y     <= '0;
            r_p     <= '0;
          end
        end
        S_RD_OLD: r_state <= S_QUANT;
        S_QUANT: begin
          r_err   <= w_err;
          r_state <= S_E;
        end
        S_E:  r_state <= S_SW;
        S_SW: r_state <= S_S;
        S_S:  r_state <= S_SE;
        S_SE: begin
          if (w_x_last && w_y_last) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_RD_OLD;
            r_p     <= r_p + PIX_W'(1);
            if (w_x_last) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
            end else begin
              r_x <= r_x + XW'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_p16     = 16'(r_p);
  assign w_x_last  = (r_x == c_X_LAST);
  assign w_x_first = (r_x == '0);
  assign w_y_last  = (r_y == c_Y_LAST);
  assign w_ok_e    = !w_x_last;
  assign w_ok_sw   = !w_y_last && !w_x_first;
  assign w_ok_s    = !w_y_last;
  assign w_ok_se   = !w_y_last && !w_x_last;
  assign pixel_idx = r_p;

  assign w_new = ({1'b0, q_a} >= c_THRESH) ? {RGB_SIZE{1'b1}} : '0;
  assign w_err = $signed({1'b0, q_a}) - $signed({1'b0, w_new});

  always_comb begin
    w_weight = 4'd0;
    case (r_state)
      S_E:     w_weight = 4'd7;
      S_SW:    w_weight = 4'd3;
      S_S:     w_weight = 4'd5;
      S_SE:    w_weight = 4'd1;
      default: w_weight = 4'd0;
    endcase
  end

  // Low 13 bits of the product are identical for signed and unsigned operands.
  assign w_prod = {{4{r_err[8]}}, r_err} * {9'b0, w_weight};

`ifdef DITHER_SATURATE_EN
  logic [9:0] w_sum;
  always_comb begin
    w_sum = {2'b00, q_a} + 10'(w_prod >>> 4);
    if (w_sum[9])      w_upd = '0;
    else if (w_sum[8]) w_upd = '1;
    else               w_upd = w_sum[7:0];
  end
`else
  assign w_upd = q_a + 8'(w_prod >>> 4);
`endif

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    rden_a = 1'b0;
    addr_a = '0;
    wren_b = 1'b0;
    addr_b = '0;
    data_b = '0;
    case (r_state)
      S_RD_OLD: begin
        busy   = 1'b1;
        rden_a = 1'b1;
        addr_a = w_p16;
      end
      S_QUANT: begin
        busy   = 1'b1;
        wren_b = 1'b1;
        addr_b = w_p16;
        data_b = w_new;
        if (w_ok_e) begin
          rden_a = 1'b1;
          addr_a = w_p16 + 16'd1;
        end
      end
      S_E: begin
        busy = 1'b1;
        if (w_ok_e) begin
          wren_b = 1'b1;
          addr_b = w_p16 + 16'd1;
          data_b = w_upd;
        end
        if (w_ok_sw) begin
          rden_a = 1'b1;
          addr_a = w_p16 + 16'(IMAGEX - 1);
        end
      end
      S_SW: begin
        busy = 1'b1;
        if (w_ok_sw) begin
          wren_b = 1'b1;
          addr_b = w_p16 + 16'(IMAGEX - 1);
          data_b = w_upd;
        end
        if (w_ok_s) begin
          rden_a = 1'b1;
          addr_a = w_p16 + 16'(IMAGEX);
        end
      end
      S_S: begin
        busy = 1'b1;
        if (w_ok_s) begin
          wren_b = 1'b1;
          addr_b = w_p16 + 16'(IMAGEX);
          data_b = w_upd;
        end
        if (w_ok_se) begin
          rden_a = 1'b1;
          addr_a = w_p16 + 16'(IMAGEX + 1);
        end
      end
      S_SE: begin
        busy = 1'b1;
        if (w_ok_se) begin
          wren_b = 1'b1;
          addr_b = w_p16 + 16'(IMAGEX + 1);
          data_b = w_upd;
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dither_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_dither_scheduler: 4x2 image bench with SRAM and Floyd-Steinberg model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dither_scheduler;

  localparam int IX   = 4;
  localparam int IY   = 2;
  localparam int TH   = 128;
  localparam int N    = IX * IY;
  localparam int LAST = 6 * N + 1;
  localparam int PW   = $clog2(N);
`ifdef DITHER_SATURATE_EN
  localparam int EXP_POS = 255;
  localparam int EXP_NEG = 0;
`else
  localparam int EXP_POS = 27;
  localparam int EXP_NEG = 241;
`endif

  logic          clk, rst_n, start, busy, done, rden_a, wren_b, load;
  logic [PW-1:0] pixel_idx;
  logic [15:0]   addr_a, addr_b;
  logic [7:0]    q_a, data_b;
  logic [7:0]    mem      [N];
  logic [7:0]    init_img [N];

  int n_pass = 0;
  int n_chk  = 0;
  int ex_rden [LAST+1], ex_raddr [LAST+1];
  int ex_wren [LAST+1], ex_waddr [LAST+1], ex_wdata [LAST+1];
  int model_img [N];

  dither_scheduler #(.IMAGEX(IX), .IMAGEY(IY), .RGB_SIZE(8), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pixel_idx(pixel_idx), .addr_a(addr_a), .rden_a(rden_a), .q_a(q_a),
    .addr_b(addr_b), .wren_b(wren_b), .data_b(data_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // SRAM: port A registered read, port B write.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= init_img[i];
    end else begin
      if (rden_a) q_a <= (int'(addr_a) < N) ? mem[addr_a[PW-1:0]] : 8'h00;
      if (wren_b && int'(addr_b) < N) mem[addr_b[PW-1:0]] <= data_b;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int upd(input int v, input int e, input int w);
    int t, s;
    t = e * w;
    t = (t >= 0) ? t / 16 : -((15 - t) / 16);
    s = v + t;
`ifdef DITHER_SATURATE_EN
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
    return s;
`else
    return s & 255;
`endif
  endfunction

  // Per-cycle expectation: cycle c after the start edge belongs to pixel (c-1)/6.
  task automatic build_model();
    int dx [4], dy [4], wt [4];
    int x, y, b, old, nw, e, nx, ny, n;
    dx = '{1, -1, 0, 1};
    dy = '{0, 1, 1, 1};
    wt = '{7, 3, 5, 1};
    for (int c = 0; c <= LAST; c++) begin
      ex_rden[c] = 0; ex_raddr[c] = 0; ex_wren[c] = 0; ex_waddr[c] = 0; ex_wdata[c] = 0;
    end
    for (int i = 0; i < N; i++) model_img[i] = int'(init_img[i]);
    for (int p = 0; p < N; p++) begin
      x = p % IX; y = p / IX; b = 6 * p + 1;
      old = model_img[p];
      nw  = (old >= TH) ? 255 : 0;
      e   = old - nw;
      ex_rden[b] = 1; ex_raddr[b] = p;
      ex_wren[b+1] = 1; ex_waddr[b+1] = p; ex_wdata[b+1] = nw;
      model_img[p] = nw;
      for (int k = 0; k < 4; k++) begin
        nx = x + dx[k]; ny = y + dy[k];
        if (nx >= 0 && nx < IX && ny < IY) begin
          n = ny * IX + nx;
          ex_rden[b+1+k] = 1; ex_raddr[b+1+k] = n;
          model_img[n] = upd(model_img[n], e, wt[k]);
          ex_wren[b+2+k] = 1; ex_waddr[b+2+k] = n; ex_wdata[b+2+k] = model_img[n];
        end
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   int'(busy),      0);
    check({tag, "_done"},   int'(done),      0);
    check({tag, "_rden_a"}, int'(rden_a),    0);
    check({tag, "_wren_b"}, int'(wren_b),    0);
    check({tag, "_addr_a"}, int'(addr_a),    0);
    check({tag, "_addr_b"}, int'(addr_b),    0);
    check({tag, "_data_b"}, int'(data_b),    0);
    check({tag, "_pix"},    int'(pixel_idx), 0);
  endtask

  task automatic load_image();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic run_image(input bit second_start, output int e_wdata);
    int n_wr;
    n_wr = 0;
    e_wdata = -1;
    load_image();
    build_model();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      check("busy", int'(busy), int'(c <= 6 * N));
      check("done", int'(done), int'(c == LAST));
      check("rden_a", int'(rden_a), ex_rden[c]);
      if (ex_rden[c] != 0) check("addr_a", int'(addr_a), ex_raddr[c]);
      check("wren_b", int'(wren_b), ex_wren[c]);
      if (ex_wren[c] != 0) begin
        check("addr_b", int'(addr_b), ex_waddr[c]);
        check("data_b", int'(data_b), ex_wdata[c]);
      end
      if (c <= 6 * N) check("pixel_idx", int'(pixel_idx), (c - 1) / 6);
      if (wren_b) n_wr++;
      if (c == 3 && wren_b) e_wdata = int'(data_b);
      start = second_start && (c == 9);
    end
    check("wren_count", n_wr, 24);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_rden", int'(rden_a), 0);
    check("idle_wren", int'(wren_b), 0);
    for (int i = 0; i < N; i++) check("mem_final", int'(mem[i]), model_img[i]);
  endtask

  initial begin
    int ew;
    rst_n = 1'b0; start = 1'b0; load = 1'b0;
    for (int i = 0; i < N; i++) init_img[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_quiet("por");
    rst_n = 1'b1;

    // Quantise high, E write; second start pulse at cycle 10 must be ignored.
    for (int i = 0; i < N; i++) init_img[i] = 8'(60 + 20 * i);
    init_img[0] = 8'd200; init_img[1] = 8'd100;
    run_image(1'b1, ew);
    check("e_write_hi", ew, 75);
    check("model_e_hi", ex_wdata[3], 75);
    check("mem0_hi", int'(mem[0]), 255);

    // Quantise low with positive overflow.
    for (int i = 0; i < N; i++) init_img[i] = 8'(37 * i);
    init_img[0] = 8'd100; init_img[1] = 8'd240;
    run_image(1'b0, ew);
    check("e_write_pos_ovf", ew, EXP_POS);
    check("model_pos_ovf", ex_wdata[3], EXP_POS);
    check("mem0_lo", int'(mem[0]), 0);

    // Negative overflow.
    init_img[0] = 8'd200; init_img[1] = 8'd10;
    run_image(1'b0, ew);
    check("e_write_neg_ovf", ew, EXP_NEG);

    // Randomised images.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) init_img[i] = 8'($urandom_range(0, 255));
      run_image(r[0], ew);
    end

    // Asynchronous reset in the middle of a run.
    for (int i = 0; i < N; i++) init_img[i] = 8'($urandom_range(0, 255));
    load_image();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat ($urandom_range(3, 40)) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_quiet("async_rst");
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_rden", int'(rden_a), 0);
      check("rst_hold_wren", int'(wren_b), 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_rden", int'(rden_a), 0);
      check("post_rst_wren", int'(wren_b), 0);
    end
    for (int i = 0; i < N; i++) init_img[i] = 8'($urandom_range(0, 255));
    run_image(1'b0, ew);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
